// File: rtl/rs_tag_allocator.sv
// -----------------------------------------------------------------------------
// rs_tag_allocator
//
// Free-entry allocator for one reservation-station or load/store pool. A
// registered busy bitmap tracks which entries are in use. The lowest-index
// free entry is offered every cycle and granted with zero latency. Two
// independent release ports (CDB/commit) return entries to the pool. A flush
// (misprediction) frees every entry at once.
//
// Ports
//   clk          clock; all state changes on the rising edge
//   rst          synchronous reset, active high
//   flush        free every entry at the next edge
//   alloc_req    dispatch asks for one entry this cycle
//   alloc_gnt    request granted this cycle (combinational)
//   alloc_tag    tag being granted, which is the lowest free tag (combinational)
//   free_valid   at least one entry is free (combinational)
//   rel0_en/tag  release port 0
//   rel1_en/tag  release port 1
//   free_cnt     number of free entries (registered)
//   full         every entry is busy (registered)
//   idle         no entry is busy (registered)
//   err_bad_rel  sticky flag: a released tag was already free or out of range
// -----------------------------------------------------------------------------
module rs_tag_allocator #(
  parameter int ENTRIES = 8,
  parameter int TAG_W   = $clog2(ENTRIES),
  parameter int CNT_W   = $clog2(ENTRIES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             alloc_req,
  output logic             alloc_gnt,
  output logic [TAG_W-1:0] alloc_tag,
  output logic             free_valid,
  input  logic             rel0_en,
  input  logic [TAG_W-1:0] rel0_tag,
  input  logic             rel1_en,
  input  logic [TAG_W-1:0] rel1_tag,
  output logic [CNT_W-1:0] free_cnt,
  output logic             full,
  output logic             idle,
  output logic             err_bad_rel
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ENTRIES-1:0] r_busy;
  logic               r_err;
  logic [CNT_W-1:0]   r_free_cnt;
  logic               r_full;
  logic               r_idle;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic [TAG_W-1:0]   w_lowest_free;
  logic               w_any_free;
  logic               w_gnt;
  logic [ENTRIES-1:0] w_alloc_mask;
  logic [ENTRIES-1:0] w_rel0_oh;
  logic [ENTRIES-1:0] w_rel1_oh;
  logic [ENTRIES-1:0] w_rel_mask;
  logic               w_rel0_hit;
  logic               w_rel1_hit;
  logic               w_rel0_bad;
  logic               w_rel1_bad;
  logic [ENTRIES-1:0] w_busy_nxt;
  logic               w_err_nxt;
  logic [CNT_W-1:0]   w_busy_cnt;
  logic [CNT_W-1:0]   w_free_cnt_nxt;

  // One-hot decode of a tag. A tag >= ENTRIES matches no bit, so
  // out-of-range releases naturally fall out as "not busy" without
  // indexing past the end of the bitmap.
  function automatic logic [ENTRIES-1:0] tag_onehot(input logic [TAG_W-1:0] tag);
    logic [ENTRIES-1:0] oh;
    oh = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      oh[i] = (tag == TAG_W'(i));
    end
    return oh;
  endfunction

  // ---------------------------------------------------------------------------
  // Lowest-free priority encoder
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default before any conditional
  // assignment; otherwise a path that skips it infers a latch.
  always_comb begin
    w_lowest_free = '0;
    w_any_free    = 1'b0;
    // Scan from the top down so the last hit written is the lowest index.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_lowest_free = TAG_W'(i);
        w_any_free    = 1'b1;
      end
    end
  end

  // Grant uses the current bitmap, so the granted entry is free now and
  // can never collide with a same-cycle release (releasing a free tag is
  // an error that leaves busy alone).
  assign w_gnt        = alloc_req & w_any_free & ~flush & ~rst;
  assign w_alloc_mask = w_gnt ? tag_onehot(w_lowest_free) : '0;

  // ---------------------------------------------------------------------------
  // Release decode
  // ---------------------------------------------------------------------------
  assign w_rel0_oh  = tag_onehot(rel0_tag);
  assign w_rel1_oh  = tag_onehot(rel1_tag);

  // Both ports are checked against the current bitmap. Two ports naming the
  // same busy tag both hit, the masks OR into a single clear and neither
  // port raises the error.
  assign w_rel0_hit = rel0_en & (|(w_rel0_oh & r_busy));
  assign w_rel1_hit = rel1_en & (|(w_rel1_oh & r_busy));
  assign w_rel0_bad = rel0_en & ~w_rel0_hit;
  assign w_rel1_bad = rel1_en & ~w_rel1_hit;

  assign w_rel_mask = (w_rel0_hit ? w_rel0_oh : '0)
                    | (w_rel1_hit ? w_rel1_oh : '0);

  // ---------------------------------------------------------------------------
  // Next-state bitmap and error flag
  // ---------------------------------------------------------------------------
  always_comb begin
    w_busy_nxt = r_busy;
    w_err_nxt  = r_err;
    if (flush) begin
      // Flush wins over alloc and release; same-cycle releases are dropped
      // without an error check, and the sticky error is kept.
      w_busy_nxt = '0;
    end else begin
      w_busy_nxt = (r_busy & ~w_rel_mask) | w_alloc_mask;
      w_err_nxt  = r_err | w_rel0_bad | w_rel1_bad;
    end
  end

  // ---------------------------------------------------------------------------
  // Occupancy counters, derived from the next-state bitmap so the registered
  // values line up with the bitmap they describe.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_busy_cnt = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_busy_cnt = w_busy_cnt + CNT_W'(w_busy_nxt[i]);
    end
  end

  assign w_free_cnt_nxt = CNT_W'(ENTRIES) - w_busy_cnt;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its next-state value from before the edge.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and returns every register, including the
    // sticky error, to its idle value on the next edge.
    if (rst) begin
      r_busy     <= '0;
      r_err      <= 1'b0;
      r_free_cnt <= CNT_W'(ENTRIES);
      r_full     <= 1'b0;
      r_idle     <= 1'b1;
    end else begin
      r_busy     <= w_busy_nxt;
      r_err      <= w_err_nxt;
      r_free_cnt <= w_free_cnt_nxt;
      r_full     <= &w_busy_nxt;
      r_idle     <= ~(|w_busy_nxt);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // While rst is high the bitmap may still hold pre-reset contents, so the
  // allocation face is forced to its reset appearance.
  assign alloc_gnt   = w_gnt;
  assign alloc_tag   = rst ? '0 : w_lowest_free;
  assign free_valid  = rst | w_any_free;
  assign free_cnt    = r_free_cnt;
  assign full        = r_full;
  assign idle        = r_idle;
  assign err_bad_rel = r_err;

endmodule
